sfir_symmetric_systolic_cfg: RTL and testbench

Next-generation even-symmetric systolic FIR for the DSP examples tree. It extends the fixed-coefficient 4-tap filter with:
- parametrised tap count and widths;
- a double-buffered runtime coefficient bank;
- a sample-valid handshake that stalls the pipeline;
- output rounding and saturation to a narrower result width.

It sits between a sample source (ADC or upstream decimator) and downstream logic that consumes `dout` and `dout_valid`.

---
 rtl/sfir_pkg.sv | 36 +++
 rtl/sfir_sym_element.sv | 39 +++
 rtl/sfir_symmetric_systolic_cfg.sv | 118 +++++++++++
 tb/tb_sfir_symmetric_systolic_cfg.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sfir_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sfir_pkg: shared helpers for the symmetric systolic FIR          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package sfir_pkg;

    typedef logic signed [127:0] wide_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int asize(input int dsize, input int nbtap);
        return 2 * dsize + 1 + clog2(nbtap);
    endfunction

    // Round half up after an arithmetic right shift, then clamp to osize bits.
    function automatic wide_t round_sat(input wide_t acc, input int shift, input int osize);
        wide_t r;
        wide_t hi;
        wide_t lo;
        r = acc;
        if (shift > 0) r = (acc + (wide_t'(1) <<< (shift - 1))) >>> shift;
        hi = (wide_t'(1) <<< (osize - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (osize - 1));
        if (r > hi) r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfir_sym_element.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sfir_sym_element: one systolic tap (pre-add, multiply, cascade)  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sfir_sym_element #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 35
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    ce,
    input  logic signed [DSIZE-1:0] coef,
    input  logic signed [DSIZE-1:0] din,
    input  logic signed [DSIZE-1:0] dmir,
    input  logic signed [ASIZE-1:0] cin,
    output logic signed [ASIZE-1:0] cout
);

    logic signed [DSIZE:0]     r_pre;
    logic signed [2*DSIZE:0]   r_prod;
    logic signed [ASIZE-1:0]   r_casc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pre  <= '0;
            r_prod <= '0;
            r_casc <= '0;
        end else if (ce) begin
            r_pre  <= (DSIZE+1)'(din) + (DSIZE+1)'(dmir);
            r_prod <= (2*DSIZE+1)'(r_pre) * (2*DSIZE+1)'(coef);
            r_casc <= cin + ASIZE'(r_prod);
        end
    end

    assign cout = r_casc;

endmodule
`default_nettype wire

// File: rtl/sfir_symmetric_systolic_cfg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sfir_symmetric_systolic_cfg: even-symmetric systolic FIR with    |
// | double-buffered coefficients, stall, rounding and saturation     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sfir_symmetric_systolic_cfg
    import sfir_pkg::*;
#(
    parameter int NBTAP = 4,
    parameter int DSIZE = 16,
    parameter int OSIZE = 24,
    parameter int SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic signed [DSIZE-1:0]   din,
    input  logic                      din_valid,
    input  logic                      coef_wr,
    input  logic [clog2(NBTAP)-1:0]   coef_addr,
    input  logic signed [DSIZE-1:0]   coef_data,
    input  logic                      coef_commit,
    output logic                      coef_settled,
    output logic signed [OSIZE-1:0]   dout,
    output logic                      dout_valid
);

    localparam int c_ASIZE = asize(DSIZE, NBTAP);
    localparam int c_TAPS  = 2 * NBTAP - 1;
    localparam int c_CW    = clog2(NBTAP + 4);

    logic signed [DSIZE-1:0]          r_dl [c_TAPS];
    logic signed [DSIZE-1:0]          r_shadow [NBTAP];
    logic signed [DSIZE-1:0]          r_active [NBTAP];
    logic [c_CW-1:0]                  r_settle;
    logic signed [OSIZE-1:0]          r_dout;
    logic                             r_dout_valid;
    logic [NBTAP:0][c_ASIZE-1:0]      w_casc;
    wide_t                            w_acc_ext;

    // din itself is the first stage of the mirror line, so 2*NBTAP-1 registers follow it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < c_TAPS; i++) r_dl[i] <= '0;
        end else if (din_valid) begin
            r_dl[0] <= din;
            for (int i = 1; i < c_TAPS; i++) r_dl[i] <= r_dl[i-1];
        end
    end

    // A write in the commit cycle is forwarded so the commit includes it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NBTAP; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NBTAP; k++) begin
                if (coef_wr && int'(coef_addr) == k) r_shadow[k] <= coef_data;
                if (coef_commit)
                    r_active[k] <= (coef_wr && int'(coef_addr) == k) ? coef_data : r_shadow[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            r_settle <= '0;
        else if (coef_commit)
            r_settle <= c_CW'(NBTAP + 3);
        else if (din_valid && r_settle != '0)
            r_settle <= r_settle - 1'b1;
    end

    assign w_casc[0] = '0;

    // Forward data is skewed by two samples per tap to line up with the cascade latency.
    for (genvar k = 0; k < NBTAP; k++) begin : g_tap
        logic signed [DSIZE-1:0] w_fwd;
        if (k == 0) begin : g_head
            assign w_fwd = din;
        end else begin : g_body
            assign w_fwd = r_dl[2*k-1];
        end
        sfir_sym_element #(
            .DSIZE (DSIZE),
            .ASIZE (c_ASIZE)
        ) u_elem (
            .clk  (clk),
            .rstn (rstn),
            .ce   (din_valid),
            .coef (r_active[k]),
            .din  (w_fwd),
            .dmir (r_dl[c_TAPS-1]),
            .cin  (w_casc[k]),
            .cout (w_casc[k+1])
        );
    end

    assign w_acc_ext = {{(128-c_ASIZE){w_casc[NBTAP][c_ASIZE-1]}}, w_casc[NBTAP]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= din_valid;
            if (din_valid) r_dout <= OSIZE'(round_sat(w_acc_ext, SHIFT, OSIZE));
        end
    end

    assign dout         = r_dout;
    assign dout_valid   = r_dout_valid;
    assign coef_settled = (r_settle == '0);

endmodule
`default_nettype wire

// File: tb/tb_sfir_symmetric_systolic_cfg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sfir_symmetric_systolic_cfg: three configurations on a shared |
// | stimulus, checked against a sample-history model every cycle     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_sfir_symmetric_systolic_cfg;

    localparam int N = 4;
    localparam int D = N + 3;

    logic               clk;
    logic               rstn;
    logic signed [15:0] din;
    logic               din_valid;
    logic               coef_wr;
    logic [1:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               coef_commit;

    logic signed [23:0] dout_a, dout_r;
    logic signed [15:0] dout_s;
    logic               dv_a, dv_s, dv_r, st_a, st_s, st_r;

    sfir_symmetric_systolic_cfg #(.NBTAP(N), .DSIZE(16), .OSIZE(24), .SHIFT(0)) u_dut_a (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .coef_wr(coef_wr),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
        .coef_settled(st_a), .dout(dout_a), .dout_valid(dv_a));

    sfir_symmetric_systolic_cfg #(.NBTAP(N), .DSIZE(16), .OSIZE(16), .SHIFT(0)) u_dut_s (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .coef_wr(coef_wr),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
        .coef_settled(st_s), .dout(dout_s), .dout_valid(dv_s));

    sfir_symmetric_systolic_cfg #(.NBTAP(N), .DSIZE(16), .OSIZE(24), .SHIFT(4)) u_dut_r (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .coef_wr(coef_wr),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
        .coef_settled(st_r), .dout(dout_r), .dout_valid(dv_r));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    bit     chk_en = 1'b0;
    bit     cap_en = 1'b0;
    longint cap_a[$];
    longint cap_r[$];

    // Model state: accepted-sample history since reset and the two coefficient sets.
    longint hist[$];
    int     sh[N];
    int     act[N];
    int     cnt;
    bit     e_valid, e_settled, e_known;
    longint e_acc;

    int imp[16] = '{0, 0, 0, 0, 0, 0, 7, 14, -138, 129, 129, -138, 14, 7, 0, 0};

    task automatic check(input string name, input logic signed [63:0] act_v,
                         input logic signed [63:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
        end
    endtask

    function automatic longint xat(input int i);
        if (i < 0 || i >= hist.size()) return 0;
        return hist[i];
    endfunction

    function automatic longint model_y(input int m);
        longint s = 0;
        for (int k = 0; k < N; k++)
            s += longint'(act[k]) * (xat(m - k) + xat(m - (2*N - 1 - k)));
        return s;
    endfunction

    function automatic longint rs(input longint acc, input int shv, input int ow);
        longint r = acc;
        longint hi = (longint'(1) <<< (ow - 1)) - 1;
        longint lo = -(longint'(1) <<< (ow - 1));
        if (shv > 0) r = (acc + (longint'(1) <<< (shv - 1))) >>> shv;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic step(input bit rn, input bit v, input int x, input bit wr = 1'b0,
                        input int addr = 0, input int data = 0, input bit cm = 1'b0);
        rstn        = rn;
        din_valid   = v;
        din         = 16'(x);
        coef_wr     = wr;
        coef_addr   = 2'(addr);
        coef_data   = 16'(data);
        coef_commit = cm;
        @(posedge clk);
        if (!rn) begin
            hist.delete();
            for (int k = 0; k < N; k++) begin sh[k] = 0; act[k] = 0; end
            cnt = 0; e_valid = 0; e_settled = 1; e_known = 1; e_acc = 0;
        end else begin
            if (wr && addr < N) sh[addr] = data;
            if (v) begin
                hist.push_back(longint'(x));
                e_acc = model_y(hist.size() - 1 - (N + 2));
            end
            if (cm) begin
                for (int k = 0; k < N; k++) act[k] = sh[k];
                cnt = D;
            end else if (v && cnt > 0) cnt--;
            e_valid   = v;
            e_settled = (cnt == 0);
            if (v) e_known = e_settled;
        end
        #1;
        if (cap_en && dv_a) begin
            cap_a.push_back(longint'(dout_a));
            cap_r.push_back(longint'(dout_r));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dout_valid_a", dv_a, e_valid);
            check("dout_valid_s", dv_s, e_valid);
            check("dout_valid_r", dv_r, e_valid);
            check("coef_settled", st_a, e_settled);
            check("coef_settled_r", st_r, e_settled);
            if (e_known) begin
                check("dout_a", dout_a, rs(e_acc, 0, 24));
                check("dout_s", dout_s, rs(e_acc, 0, 16));
                check("dout_r", dout_r, rs(e_acc, 4, 24));
            end
        end
    end

    task automatic program_set(input int h0, input int h1, input int h2, input int h3);
        int hv[N];
        hv = '{h0, h1, h2, h3};
        for (int k = 0; k < N; k++) step(1, 0, 0, 1, k, hv[k]);
        step(1, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic check_impulse(input string name);
        check({name, "_len"}, cap_a.size(), 16);
        for (int i = 0; i < 16 && i < cap_a.size(); i++)
            check(name, cap_a[i], imp[i]);
    endtask

    initial begin
        int nacc, it, n, nz;
        int newset[N];
        newset = '{3, -5, 11, 2};

        step(0, 0, 0);
        chk_en = 1'b1;
        step(0, 0, 0);
        check("rst_settled", st_a, 1);
        check("rst_dout", dout_a, 0);
        check("rst_valid", dv_a, 0);

        // Impulse response
        program_set(7, 14, -138, 129);
        repeat (D) step(1, 1, 0);
        cap_a.delete(); cap_r.delete(); cap_en = 1'b1;
        step(1, 1, 1);
        repeat (15) step(1, 1, 0);
        cap_en = 1'b0;
        check_impulse("impulse");

        // Same impulse with random stalls and junk on din while invalid
        cap_a.delete(); cap_r.delete(); cap_en = 1'b1;
        nacc = 0; it = 0;
        while (nacc < 16 && it < 400) begin
            bit v;
            v = 1'($urandom_range(0, 1));
            step(1, v, v ? ((nacc == 0) ? 1 : 0) : 12345);
            if (v) nacc++;
            it++;
        end
        cap_en = 1'b0;
        check_impulse("stall_impulse");

        // Saturation
        repeat (20) step(1, 1, 32767);
        check("sat_pos_o16", dout_s, 32767);
        check("sat_pos_o24", dout_a, 786408);
        repeat (20) step(1, 1, -32768);
        check("sat_neg_o16", dout_s, -32768);
        check("sat_neg_o24", dout_a, -786432);
        repeat (16) step(1, 1, 0);

        // Rounding
        program_set(7, 0, 0, 0);
        repeat (D) step(1, 1, 0);
        cap_a.delete(); cap_r.delete(); cap_en = 1'b1;
        step(1, 1, 8);
        repeat (7) step(1, 1, 0);
        cap_en = 1'b0;
        check("round_pos_len", cap_r.size(), 8);
        if (cap_r.size() > 6) check("round_pos", cap_r[6], 4);
        cap_a.delete(); cap_r.delete(); cap_en = 1'b1;
        step(1, 1, -8);
        repeat (7) step(1, 1, 0);
        cap_en = 1'b0;
        check("round_neg_len", cap_r.size(), 8);
        if (cap_r.size() > 6) check("round_neg", cap_r[6], -3);
        repeat (8) step(1, 1, 0);

        // Coefficient swap while streaming, commit carries a simultaneous write
        for (int i = 0; i < 12; i++)
            step(1, 1, (i * 37) % 200 - 100, i < N, i % N, newset[i % N]);
        step(1, 1, 55, 1, 3, 20, 1);
        n = 0;
        while (st_a == 1'b0 && n < 20) begin
            step(1, 1, (n * 53) % 300 - 150);
            n++;
        end
        check("settle_len", n, D);
        for (int i = 0; i < 20; i++)
            step(1, (i % 3) != 2, (i * 91) % 500 - 250);

        // Reset in the middle of an impulse response
        step(1, 1, 1);
        repeat (3) step(1, 1, 0);
        step(0, 1, 5);
        check("midrst_valid", dv_a, 0);
        check("midrst_dout", dout_a, 0);
        check("midrst_settled", st_a, 1);
        nz = 0;
        repeat (12) begin
            step(1, 1, 100);
            if (dv_a && dout_a != 0) nz++;
        end
        check("post_rst_zero", nz, 0);

        step(1, 0, 0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
